// File: rtl/imm_gen_stage.sv
// RISC-V immediate generator behind a 2-entry skid FIFO (output register + skid register).
// Optional macro IMM_ZICSR_EN enables the Z format (zero-extended CSR uimm from inst[19:15]).
module imm_gen_stage #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int AUTO_FMT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_Z   = 3'b101;
    localparam logic [2:0] FMT_BAD = 3'b111;

    function automatic logic [2:0] opcode_fmt(input logic [31:0] i);
        logic [2:0] f;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
            7'b0100011:                         f = FMT_S;
            7'b1100011:                         f = FMT_B;
            7'b0110111, 7'b0010111:             f = FMT_U;
            7'b1101111:                         f = FMT_J;
`ifdef IMM_ZICSR_EN
            7'b1110011:                         f = i[14] ? FMT_Z : FMT_I;
`else
            7'b1110011:                         f = FMT_I;
`endif
            default:                            f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic logic [2:0] check_fmt(input logic [2:0] f);
        logic [2:0] r;
        case (f)
            FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: r = f;
`ifdef IMM_ZICSR_EN
            FMT_Z:                             r = FMT_Z;
`endif
            default:                           r = FMT_BAD;
        endcase
        return r;
    endfunction

    // Build the 32-bit signed immediate, then sign-extend to XLEN (Z is zero-extended).
    function automatic logic [XLEN-1:0] build_imm(input logic [31:0] i, input logic [2:0] f);
        logic signed [31:0] s;
        logic [XLEN-1:0]    r;
        case (f)
            FMT_I:   s = {{20{i[31]}}, i[31:20]};
            FMT_S:   s = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   s = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   s = {i[31:12], 12'b0};
            FMT_J:   s = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: s = '0;
        endcase
        r = XLEN'(s);
`ifdef IMM_ZICSR_EN
        if (f == FMT_Z) r = XLEN'(i[19:15]);
`endif
        return r;
    endfunction

    logic [1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  imm_q, imm_d, skid_imm_q, skid_imm_d;
    logic [2:0]       fmt_q, fmt_d, skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0] tag_q, tag_d, skid_tag_q, skid_tag_d;
    logic             ill_q, ill_d, skid_ill_q, skid_ill_d;

    logic [2:0]       res_fmt;
    logic [XLEN-1:0]  res_imm;
    logic             res_ill;
    logic             push, pop;

    assign in_ready    = (cnt_q < 2'd2);
    assign out_valid   = (cnt_q != 2'd0);
    assign out_imm     = imm_q;
    assign out_fmt     = fmt_q;
    assign out_tag     = tag_q;
    assign out_illegal = ill_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        res_fmt = (AUTO_FMT != 0) ? opcode_fmt(inst) : check_fmt(fmt);
        res_imm = build_imm(inst, res_fmt);
        res_ill = (res_fmt == FMT_BAD);
    end

    // Occupancy 1 keeps the head in the output register; a second entry parks in the skid register.
    always_comb begin
        cnt_d      = cnt_q;
        imm_d      = imm_q;
        fmt_d      = fmt_q;
        tag_d      = tag_q;
        ill_d      = ill_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        {imm_d, fmt_d, tag_d, ill_d} = {res_imm, res_fmt, in_tag, res_ill};
                        cnt_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        {imm_d, fmt_d, tag_d, ill_d} = {res_imm, res_fmt, in_tag, res_ill};
                    end else if (push) begin
                        {skid_imm_d, skid_fmt_d, skid_tag_d, skid_ill_d} =
                            {res_imm, res_fmt, in_tag, res_ill};
                        cnt_d = 2'd2;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        {imm_d, fmt_d, tag_d, ill_d} = {skid_imm_q, skid_fmt_q, skid_tag_q, skid_ill_q};
                        cnt_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            imm_q      <= '0;
            fmt_q      <= 3'b000;
            tag_q      <= '0;
            ill_q      <= 1'b0;
            skid_imm_q <= '0;
            skid_fmt_q <= 3'b000;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            imm_q      <= imm_d;
            fmt_q      <= fmt_d;
            tag_q      <= tag_d;
            ill_q      <= ill_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: a selector-driven XLEN=32 instance and an opcode-driven XLEN=64 instance.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [4:0]  in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_tag;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [63:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [4:0]  a_out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(5), .AUTO_FMT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .fmt(fmt), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5), .AUTO_FMT(1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst(inst), .fmt(fmt), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_tag(a_out_tag), .out_illegal(a_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [2:0] f, input logic [4:0] t);
        in_valid = 1'b1;
        inst     = i;
        fmt      = f;
        in_tag   = t;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; fmt = '0; in_tag = '0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_tag_fmt_ill", 64'({out_tag, out_fmt, out_illegal}), 64'd0);
        rst_n = 1'b1;
        step();

        offer(32'hFFF00093, 3'b000, 5'd1);
        step();
        chk("i_valid", 64'(out_valid), 64'd1);
        chk("i_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("i_fmt", 64'(out_fmt), 64'd0);
        chk("i_imm64", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        offer(32'hFE000EE3, 3'b010, 5'd2);
        step();
        chk("b_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("b_tag", 64'(out_tag), 64'd2);
        chk("b_fmt_auto", 64'(a_out_fmt), 64'd2);
        offer(32'h123450B7, 3'b011, 5'd3);
        step();
        chk("u_imm", 64'(out_imm), 64'h1234_5000);
        chk("u_tag", 64'(out_tag), 64'd3);
        chk("u_imm64", a_out_imm, 64'h0000_0000_1234_5000);
        offer(32'h0040006F, 3'b100, 5'd4);
        step();
        chk("j_imm", 64'(out_imm), 64'h0000_0004);
        chk("j_tag", 64'(out_tag), 64'd4);
        chk("j_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("empty_hold_imm", 64'(out_imm), 64'h0000_0004);

        out_ready = 1'b0;
        offer(32'h00100093, 3'b000, 5'd10);
        step();
        chk("stall_ready1", 64'(in_ready), 64'd1);
        offer(32'h00200093, 3'b000, 5'd11);
        step();
        chk("stall_ready_full", 64'(in_ready), 64'd0);
        chk("stall_tag_a", 64'(out_tag), 64'd10);
        offer(32'h00300093, 3'b000, 5'd12);
        step();
        chk("stall_held_ready", 64'(in_ready), 64'd0);
        chk("stall_stable_imm", 64'(out_imm), 64'd1);
        chk("stall_stable_tag", 64'(out_tag), 64'd10);
        out_ready = 1'b1;
        step();
        chk("deliver_b_tag", 64'(out_tag), 64'd11);
        chk("deliver_b_imm", 64'(out_imm), 64'd2);
        step();
        chk("deliver_c_tag", 64'(out_tag), 64'd12);
        chk("deliver_c_imm", 64'(out_imm), 64'd3);
        in_valid = 1'b0;
        step();
        chk("deliver_done", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        offer(32'h00500093, 3'b000, 5'd20);
        step();
        offer(32'h00600093, 3'b000, 5'd21);
        step();
        chk("pre_flush_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        offer(32'h00700093, 3'b000, 5'd22);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("flush_no_reappear", 64'(out_valid), 64'd0);

        offer(32'h00000000, 3'b110, 5'd5);
        step();
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_imm", 64'(out_imm), 64'd0);
        chk("ill_fmt", 64'(out_fmt), 64'd7);
        chk("ill_auto", 64'({a_out_illegal, a_out_fmt}), 64'hF);
        chk("ill_tag", 64'(out_tag), 64'd5);

        offer(32'h3400D073, 3'b000, 5'd6);
        step();
        chk("csr_sel_imm", 64'(out_imm), 64'h340);
        chk("csr_sel_fmt", 64'(out_fmt), 64'd0);
`ifdef IMM_ZICSR_EN
        chk("csr_auto_imm", a_out_imm, 64'd1);
        chk("csr_auto_fmt", 64'(a_out_fmt), 64'd5);
`else
        chk("csr_auto_imm", a_out_imm, 64'h340);
        chk("csr_auto_fmt", 64'(a_out_fmt), 64'd0);
`endif
        offer(32'h00000073, 3'b101, 5'd7);
        step();
`ifdef IMM_ZICSR_EN
        chk("z_sel_fmt", 64'(out_fmt), 64'd5);
`else
        chk("z_sel_fmt", 64'(out_fmt), 64'd7);
`endif
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        offer(32'hFFF00093, 3'b000, 5'd30);
        step();
        offer(32'hFFF00093, 3'b000, 5'd31);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_imm", 64'(out_imm), 64'd0);
        chk("async_rst_tag_fmt", 64'({out_tag, out_fmt, out_illegal}), 64'd0);
        chk("async_rst_imm64", a_out_imm, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
